// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - handshake state encoding shared by the cdc source and destination controllers
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - two-stage flip-flop synchroniser for signals arriving from another clock domain
module sync_ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_src_ctrl.sv
// rtl/cdc_src_ctrl.sv - source side of a four-phase req/ack crossing with hold-stable data and timeout flag
module cdc_src_ctrl
    import cdc_pkg::*;
#(
    parameter int W    = 32,
    parameter int TO_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         xreq,
    output logic [W-1:0] xdata,
    input  logic         xack,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [TO_W-1:0] TO_MAX = '1;

    cdc_state_t      state;
    cdc_state_t      state_nxt;
    logic            ack_s;
    logic            accept;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_inc;

    sync_ff #(.W(1)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (xack),
        .q   (ack_s)
    );

    // A stale ack (e.g. still high after a reset) blocks acceptance until it clears.
    assign in_rdy = (state == IDLE) && !ack_s;
    assign busy   = (state != IDLE);
    assign accept = in_vld && in_rdy;
    assign to_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (ack_s)  state_nxt = REL;
            REL:     if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            xreq   <= 1'b0;
            xdata  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            to_cnt <= '0;
        end else begin
            state <= state_nxt;
            xreq  <= (state_nxt == REQ);
            done  <= (state == REL) && (state_nxt == IDLE);
            if (accept) begin
                xdata <= in_data;
            end
            // Threshold is judged on the incremented value so a coincident transition still flags it.
            if (busy && (to_inc == TO_MAX)) begin
                err <= 1'b1;
            end
            if (!busy || (state_nxt != state)) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_inc;
            end
        end
    end

endmodule

// File: tb/tb_cdc_src_ctrl.sv
// tb/tb_cdc_src_ctrl.sv - self-checking bench for cdc_src_ctrl with remote ack model and data scoreboard
module tb_cdc_src_ctrl;

    localparam int W    = 32;
    localparam int TO_W = 4;
    localparam int RDLY = 3;

    typedef struct {
        logic         vld;
        logic [W-1:0] data;
        logic         ack;
        logic         e_rdy;
        logic         e_xreq;
        logic         e_busy;
        logic         e_done;
        logic         e_err;
        logic [W-1:0] e_xdata;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] in_data = '0;
    logic         xreq;
    logic [W-1:0] xdata;
    logic         xack = 1'b0;
    logic         busy;
    logic         done;
    logic         err;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] sb_q[$];
    logic         remote_en = 1'b0;
    logic         prev_xreq = 1'b0;
    logic         ackm1 = 1'b0;
    logic         ackm2 = 1'b0;
    logic         prev_acks = 1'b0;
    int           rcnt = 0;

    always #5 clk = ~clk;

    cdc_src_ctrl #(.W(W), .TO_W(TO_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .xreq    (xreq),
        .xdata   (xdata),
        .xack    (xack),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0b required %0b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model remote + synchroniser, sample 1 ns after posedge.
    task automatic tick(input logic vld, input logic [W-1:0] data, input logic ack, output logic acc);
        @(negedge clk);
        in_vld  = vld;
        in_data = data;
        if (remote_en) begin
            if (xack != xreq) begin
                if (rcnt == RDLY - 1) begin
                    xack = xreq;
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end else begin
            xack = ack;
        end
        acc = vld && in_rdy && !rst;
        if (acc) sb_q.push_back(data);
        @(posedge clk);
        prev_acks = ackm2;
        if (rst) begin
            ackm1 = 1'b0;
            ackm2 = 1'b0;
        end else begin
            ackm2 = ackm1;
            ackm1 = xack;
        end
        #1;
        chk1("in_rdy_vs_sync_model", in_rdy, !busy && !ackm2);
        if (xreq && !prev_xreq) begin
            chk1("xreq_rise_over_ack", prev_acks, 1'b0);
            if (sb_q.size() > 0) chk("xdata_at_req", xdata, sb_q[0]);
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: actual done=1 required no pending word at %0t", $time);
            end else begin
                chk("xdata_at_done", xdata, sb_q.pop_front());
            end
        end
        prev_xreq = xreq;
    endtask

    initial begin
        vec_t tv[12];
        logic acc;
        logic dprev;
        int   idx;
        int   ndone;
        int   b2b;
        int   budget;

        //          vld   data          ack   rdy   xreq  busy  done  err   xdata
        tv[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

        // Reset state
        tick(1'b0, '0, 1'b0, acc);
        tick(1'b0, '0, 1'b0, acc);
        rst = 1'b0;
        sb_q.delete();
        chk1("rst_xreq", xreq, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_xdata", xdata, '0);

        // Single transfer, cycle by cycle
        foreach (tv[i]) begin
            tick(tv[i].vld, tv[i].data, tv[i].ack, acc);
            chk1($sformatf("t1_r%0d_in_rdy", i), in_rdy, tv[i].e_rdy);
            chk1($sformatf("t1_r%0d_xreq", i), xreq, tv[i].e_xreq);
            chk1($sformatf("t1_r%0d_busy", i), busy, tv[i].e_busy);
            chk1($sformatf("t1_r%0d_done", i), done, tv[i].e_done);
            chk1($sformatf("t1_r%0d_err", i), err, tv[i].e_err);
            chk($sformatf("t1_r%0d_xdata", i), xdata, tv[i].e_xdata);
        end

        // Back-to-back words 1..4 with in_vld held high
        remote_en = 1'b1;
        idx = 0;
        ndone = 0;
        b2b = 0;
        budget = 0;
        dprev = 1'b0;
        while (ndone < 4 && budget < 300) begin
            tick(idx < 4, idx + 1, 1'b0, acc);
            if (acc) begin
                if (dprev) b2b++;
                idx++;
            end
            if (done) ndone++;
            dprev = done;
            budget++;
        end
        chk("b2b_done_count", ndone, 4);
        chk("b2b_accepts", idx, 4);
        chk("b2b_accept_in_done_cycle", b2b, 3);
        chk1("b2b_err", err, 1'b0);
        chk("b2b_last_xdata", xdata, 32'h4);

        // Backpressure during REQ and REL
        tick(1'b1, 32'hA5A5A5A5, 1'b0, acc);
        chk1("bp_accept", acc, 1'b1);
        budget = 0;
        while (!done && budget < 60) begin
            tick((budget % 2) == 1, 32'hBAD00000 | budget, 1'b0, acc);
            chk1("bp_no_accept", acc, 1'b0);
            chk("bp_xdata", xdata, 32'hA5A5A5A5);
            if (busy) chk1("bp_in_rdy", in_rdy, 1'b0);
            budget++;
        end
        chk1("bp_done", done, 1'b1);
        tick(1'b0, '0, 1'b0, acc);

        // Timeout with no ack, then a late ack
        remote_en = 1'b0;
        tick(1'b1, 32'h77, 1'b0, acc);
        chk1("to_accept", acc, 1'b1);
        for (int i = 1; i < 15; i++) begin
            tick(1'b0, '0, 1'b0, acc);
            chk1("to_err_early", err, 1'b0);
            chk1("to_xreq_held", xreq, 1'b1);
        end
        tick(1'b0, '0, 1'b0, acc);
        chk1("to_err_at_15", err, 1'b1);
        chk1("to_xreq_at_15", xreq, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b0, acc);
            chk1("to_err_saturated", err, 1'b1);
            chk1("to_xreq_saturated", xreq, 1'b1);
        end
        budget = 0;
        while (xreq && budget < 20) begin
            tick(1'b0, '0, 1'b1, acc);
            budget++;
        end
        chk1("to_req_released", xreq, 1'b0);
        budget = 0;
        while (!done && budget < 20) begin
            tick(1'b0, '0, 1'b0, acc);
            budget++;
        end
        chk1("to_late_done", done, 1'b1);
        chk1("to_err_sticky", err, 1'b1);
        tick(1'b0, '0, 1'b0, acc);
        chk1("to_err_sticky_idle", err, 1'b1);
        chk1("to_idle", busy, 1'b0);

        // Reset mid-REQ with raw ack high
        tick(1'b1, 32'h55, 1'b0, acc);
        chk1("rr_accept", acc, 1'b1);
        tick(1'b0, '0, 1'b1, acc);
        chk1("rr_xreq_before", xreq, 1'b1);
        rst = 1'b1;
        tick(1'b0, '0, 1'b1, acc);
        rst = 1'b0;
        sb_q.delete();
        chk1("rr_xreq", xreq, 1'b0);
        chk("rr_xdata", xdata, '0);
        chk1("rr_busy", busy, 1'b0);
        chk1("rr_err_cleared", err, 1'b0);
        tick(1'b0, '0, 1'b1, acc);
        tick(1'b0, '0, 1'b1, acc);
        chk1("rr_rdy_stale", in_rdy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h99, 1'b1, acc);
            chk1("rr_no_accept", acc, 1'b0);
            chk1("rr_no_req", xreq, 1'b0);
            chk1("rr_rdy_held", in_rdy, 1'b0);
        end
        tick(1'b0, '0, 1'b0, acc);
        chk1("rr_rdy_sync_pending", in_rdy, 1'b0);
        tick(1'b0, '0, 1'b0, acc);
        chk1("rr_rdy_release", in_rdy, 1'b1);
        chk("rr_xdata_kept", xdata, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_src_ctrl.md
Name: cdc_src_ctrl

Overview:
- Source-side controller for a four-phase req/ack clock-domain crossing.
- Accepts one word from a local valid/ready producer and holds it stable on `xdata`.
- Sequences `xreq` against an `xack` returned asynchronously from the remote domain; `xack` is synchronised internally.
- Sits at the boundary of the local clock domain. The matching destination-side controller lives in the remote domain.

Parameters:
- W, 32, width of the transferred data word.
- TO_W, 8, width of the handshake-phase timeout counter; timeout threshold is 2^TO_W-1 cycles.

Ports:
- clk  in  1  local clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  producer has a word.
- in_rdy  out  1  controller can accept a word this cycle.
- in_data  in  W  producer word; sampled when in_vld && in_rdy.
- xreq  out  1  request to the remote domain; registered.
- xdata  out  W  crossing data; registered, stable whenever xreq=1 or ack is pending.
- xack  in  1  acknowledge from the remote domain; asynchronous to clk.
- busy  out  1  handshake in progress (state != IDLE).
- done  out  1  single-cycle pulse when a transfer completes.
- err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Ack synchronisation: `xack` passes through a 2-stage sync_ff (W=1, reset by rst) to produce ack_s. ack_s lags xack by 2 clk edges. No other logic touches raw xack.
- Reset values: state=IDLE, xreq=0, xdata=0, done=0, err=0, timeout count=0, ack_s=0.
- States (held in a registered state register):
  - IDLE: xreq=0.
    - in_rdy = (state==IDLE) && !ack_s; combinational, no dependence on in_vld.
    - On in_vld && in_rdy: xdata<=in_data, xreq<=1, go to REQ. xreq is visible the cycle after acceptance.
  - REQ: xreq=1, waiting for ack_s=1.
    - On ack_s=1: xreq<=0, go to REL.
  - REL: xreq=0, waiting for ack_s=0.
    - On ack_s=0: done<=1 for exactly one cycle, go to IDLE.
- Latency:
  - Minimum accept-to-done latency is 2 + 2·(remote response) + 4 synchroniser cycles.
  - Back-to-back acceptance is possible in the cycle done is high, since state=IDLE and ack_s=0.
- Data stability: xdata changes only on acceptance. It is held through REQ, REL and IDLE until the next acceptance.
- Post-reset ack high: if raw xack is still 1 after a reset mid-transfer, ack_s rises 2 cycles later. in_rdy then stays 0 until ack_s returns to 0. No new request is issued over a stale ack.
- Reset mid-operation: xreq drops on the reset edge and xdata clears. The remote side must tolerate an early req fall; this is a documented system constraint.
- Timeout:
  - The counter clears on every state transition and in IDLE.
  - It increments each cycle in REQ or REL and saturates at 2^TO_W-1.
  - When the count reaches 2^TO_W-1, err<=1. err is sticky until rst.
  - The handshake continues normally after a timeout; err is informational only.
- Simultaneous events:
  - done and a new acceptance in the same cycle are legal.
  - An ack_s change coincident with timeout saturation: the transition wins, the counter clears, and err still sets if the threshold was reached that cycle.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Package cdc_pkg: state enum type (IDLE, REQ, REL) as a 2-bit logic typedef, shared with the future destination-side controller cdc_dst_ctrl.
- One sub-module: sync_ff #(.W(1)) on xack. The timeout counter stays inline; no further hierarchy.

Test Plan:
1. Single transfer: after reset, in_vld=1 with in_data=0xDEADBEEF. A remote model asserts xack 3 cycles after xreq rises and drops it 3 cycles after xreq falls. Required: xreq rises 1 cycle after accept; xdata=0xDEADBEEF throughout; xreq falls 2 cycles after xack rises; done pulses 2 cycles after xack falls; err=0.
2. Back-to-back: 4 words 0x1..0x4 with in_vld held high. Required: exactly 4 done pulses; acceptance occurs in each done cycle; the xdata sequence is 1,2,3,4; no xreq rise while ack_s=1.
3. Timeout: TO_W=4 and the remote never acks. Required: err=1 exactly 15 cycles after entering REQ; xreq stays 1. A late xack then completes the transfer with done=1 and err stays 1.
4. Reset mid-REQ: assert rst for 1 cycle while xreq=1 and xack=1. Required: next cycle xreq=0, xdata=0, busy=0. in_rdy=0 until 2 cycles after xack drops, then in_rdy=1.
5. Backpressure: in_vld pulses during REQ and REL. Required: in_rdy=0, xdata unchanged, and no extra acceptance.
